ring_accumulation_buffer: RTL

Parametrised N-bank accumulation buffer for the systolic-array output path. It succeeds the two-bank accumulation buffer with three changes: a configurable bank count arranged as a ring, an internal read-modify-write accumulate pipeline with hazard forwarding, and a writeback read port on the bank most recently retired. The array writes partial sums into the accumulate bank while the output writer drains the retired bank. `switch_banks` rotates the ring.

---
 rtl/ring_accumulation_buffer_pkg.sv | 49 ++++
 rtl/ring_accumulation_buffer_bank.sv | 40 ++++
 rtl/ring_accumulation_buffer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ring_accumulation_buffer_pkg.sv
// Shared types and helpers for the ring accumulation buffer: pointer width,
// the stage-1 write record and the wrap/saturate adder.
package acc_buf_pkg;

  // Upper bounds for the width-generic stage-1 record; instances zero-extend into it.
  localparam int unsigned ACC_MAX_DW = 128;
  localparam int unsigned ACC_MAX_AW = 16;
  localparam int unsigned ACC_MAX_PW = 8;

  function automatic int unsigned ptr_width(input int unsigned num_banks);
    return (num_banks < 2) ? 1 : $clog2(num_banks);
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [ACC_MAX_PW-1:0] bank;
    logic [ACC_MAX_AW-1:0] adr;
    logic [ACC_MAX_DW-1:0] result;
  } stage1_t;

  // Adds two width-bit two's complement values held zero-extended in ACC_MAX_DW
  // bits. The result is again zero-extended; saturate selects clamping on overflow.
  function automatic logic [ACC_MAX_DW-1:0] sat_add(
    input logic [ACC_MAX_DW-1:0] a,
    input logic [ACC_MAX_DW-1:0] b,
    input int unsigned           width,
    input logic                  saturate
  );
    logic [ACC_MAX_DW-1:0] mask;
    logic [ACC_MAX_DW-1:0] smax;
    logic [ACC_MAX_DW-1:0] sbit;
    logic [ACC_MAX_DW-1:0] sum;
    logic                  sa;
    logic                  sb;
    logic                  ss;
    mask = {ACC_MAX_DW{1'b1}} >> (ACC_MAX_DW - width);
    smax = mask >> 1;
    sbit = mask & ~smax;
    sum  = (a + b) & mask;
    sa   = |(a & sbit);
    sb   = |(b & sbit);
    ss   = |(sum & sbit);
    if (saturate && (sa == sb) && (ss != sa)) begin
      sum = sa ? sbit : smax;
    end
    return sum;
  endfunction

endpackage

// File: rtl/ring_accumulation_buffer_bank.sv
// One accumulation bank: synchronous write port plus two registered read ports
// (accumulate read-modify-write, and direct/writeback read).
module acc_bank #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DEPTH      = 128
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wadr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] rd_adr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] rd_adr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_a_q;
  logic [DATA_WIDTH-1:0] rd_data_b_q;

  // Read-first: a read colliding with a write returns the old word; the top forwards.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wadr] <= wdata;
    end
    if (rd_en_a) begin
      rd_data_a_q <= mem[rd_adr_a];
    end
    if (rd_en_b) begin
      rd_data_b_q <= mem[rd_adr_b];
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;

endmodule

// File: rtl/ring_accumulation_buffer.sv
// Ring of NUM_BANKS accumulation banks with a two-stage read-modify-write pipeline.
// Define ACC_BUF_SATURATE_EN for a saturating accumulate add; by default it wraps.
module ring_accumulation_buffer
  import acc_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned BANK_ADDR_WIDTH = 7,
  parameter int unsigned BANK_DEPTH      = 128,
  parameter int unsigned NUM_BANKS       = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         switch_banks,
  input  logic                         acc_valid,
  input  logic                         acc_init,
  input  logic [BANK_ADDR_WIDTH-1:0]   acc_adr,
  input  logic [DATA_WIDTH-1:0]        acc_data,
  input  logic                         ren,
  input  logic [BANK_ADDR_WIDTH-1:0]   radr,
  output logic [DATA_WIDTH-1:0]        rdata,
  input  logic                         ren_wb,
  input  logic [BANK_ADDR_WIDTH-1:0]   radr_wb,
  output logic [DATA_WIDTH-1:0]        rdata_wb,
  output logic [$clog2(NUM_BANKS)-1:0] acc_ptr,
  output logic                         acc_busy
);

  localparam int unsigned PTR_W = ptr_width(NUM_BANKS);

`ifdef ACC_BUF_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic [PTR_W-1:0]           acc_ptr_q;
  logic [PTR_W-1:0]           acc_ptr_d;
  logic [PTR_W-1:0]           wb_ptr;

  logic                       st1_valid_q;
  logic                       st1_valid_d;
  logic                       st1_init_q;
  logic                       st1_init_d;
  logic [PTR_W-1:0]           st1_bank_q;
  logic [PTR_W-1:0]           st1_bank_d;
  logic [BANK_ADDR_WIDTH-1:0] st1_adr_q;
  logic [BANK_ADDR_WIDTH-1:0] st1_adr_d;
  logic [DATA_WIDTH-1:0]      st1_data_q;
  logic [DATA_WIDTH-1:0]      st1_data_d;
  logic                       st1_fwd_q;
  logic                       st1_fwd_d;
  logic [ACC_MAX_DW-1:0]      st1_fwd_val_q;
  logic [ACC_MAX_DW-1:0]      st1_fwd_val_d;

  stage1_t                    st1;
  logic [ACC_MAX_DW-1:0]      old_ext;
  logic [ACC_MAX_DW-1:0]      add_ext;
  logic                       wr_en;
  logic [DATA_WIDTH-1:0]      wr_data;

  logic                       rd_pend_q;
  logic                       rd_pend_d;
  logic [PTR_W-1:0]           rd_sel_q;
  logic [PTR_W-1:0]           rd_sel_d;
  logic                       rd_fwd_q;
  logic                       rd_fwd_d;
  logic [DATA_WIDTH-1:0]      rd_fwd_val_q;
  logic [DATA_WIDTH-1:0]      rd_fwd_val_d;
  logic [DATA_WIDTH-1:0]      rd_hold_q;
  logic [DATA_WIDTH-1:0]      rd_hold_d;
  logic [DATA_WIDTH-1:0]      rd_live;

  logic                       wb_pend_q;
  logic                       wb_pend_d;
  logic [PTR_W-1:0]           wb_sel_q;
  logic [PTR_W-1:0]           wb_sel_d;
  logic                       wb_fwd_q;
  logic                       wb_fwd_d;
  logic [DATA_WIDTH-1:0]      wb_fwd_val_q;
  logic [DATA_WIDTH-1:0]      wb_fwd_val_d;
  logic [DATA_WIDTH-1:0]      wb_hold_q;
  logic [DATA_WIDTH-1:0]      wb_hold_d;
  logic [DATA_WIDTH-1:0]      wb_live;

  logic [DATA_WIDTH-1:0]      bank_rd_a [NUM_BANKS];
  logic [DATA_WIDTH-1:0]      bank_rd_b [NUM_BANKS];

  always_comb begin
    wb_ptr    = (acc_ptr_q == '0) ? PTR_W'(NUM_BANKS - 1) : acc_ptr_q - 1'b1;
    acc_ptr_d = acc_ptr_q;
    if (switch_banks) begin
      acc_ptr_d = (acc_ptr_q == PTR_W'(NUM_BANKS - 1)) ? '0 : acc_ptr_q + 1'b1;
    end
  end

  // Stage 1: merge RAM word (or the forwarded previous result) with the addend.
  always_comb begin
    old_ext    = st1_fwd_q ? st1_fwd_val_q : ACC_MAX_DW'(bank_rd_a[st1_bank_q]);
    add_ext    = sat_add(old_ext, ACC_MAX_DW'(st1_data_q), DATA_WIDTH, SAT_EN);
    st1.valid  = st1_valid_q;
    st1.bank   = ACC_MAX_PW'(st1_bank_q);
    st1.adr    = ACC_MAX_AW'(st1_adr_q);
    st1.result = st1_init_q ? ACC_MAX_DW'(st1_data_q) : add_ext;
    wr_en      = st1_valid_q && rst_n;
    wr_data    = st1.result[DATA_WIDTH-1:0];
  end

  // Stage 0: latch the request; the RAM read issued now misses the stage-1 write.
  always_comb begin
    st1_valid_d   = acc_valid;
    st1_init_d    = acc_init;
    st1_bank_d    = acc_ptr_q;
    st1_adr_d     = acc_adr;
    st1_data_d    = acc_data;
    st1_fwd_d     = st1.valid && (st1.bank == ACC_MAX_PW'(acc_ptr_q))
                    && (st1.adr == ACC_MAX_AW'(acc_adr));
    st1_fwd_val_d = st1.result;
  end

  always_comb begin
    rd_pend_d    = ren;
    rd_sel_d     = acc_ptr_q;
    rd_fwd_d     = st1.valid && (st1.bank == ACC_MAX_PW'(acc_ptr_q))
                   && (st1.adr == ACC_MAX_AW'(radr));
    rd_fwd_val_d = wr_data;
    rd_live      = rd_fwd_q ? rd_fwd_val_q : bank_rd_b[rd_sel_q];
    rdata        = rd_pend_q ? rd_live : rd_hold_q;
    rd_hold_d    = rdata;

    wb_pend_d    = ren_wb;
    wb_sel_d     = wb_ptr;
    wb_fwd_d     = st1.valid && (st1.bank == ACC_MAX_PW'(wb_ptr))
                   && (st1.adr == ACC_MAX_AW'(radr_wb));
    wb_fwd_val_d = wr_data;
    wb_live      = wb_fwd_q ? wb_fwd_val_q : bank_rd_b[wb_sel_q];
    rdata_wb     = wb_pend_q ? wb_live : wb_hold_q;
    wb_hold_d    = rdata_wb;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_ptr_q   <= '0;
      st1_valid_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_hold_q   <= '0;
      wb_pend_q   <= 1'b0;
      wb_hold_q   <= '0;
    end else begin
      acc_ptr_q   <= acc_ptr_d;
      st1_valid_q <= st1_valid_d;
      rd_pend_q   <= rd_pend_d;
      rd_hold_q   <= rd_hold_d;
      wb_pend_q   <= wb_pend_d;
      wb_hold_q   <= wb_hold_d;
    end
    st1_init_q    <= st1_init_d;
    st1_bank_q    <= st1_bank_d;
    st1_adr_q     <= st1_adr_d;
    st1_data_q    <= st1_data_d;
    st1_fwd_q     <= st1_fwd_d;
    st1_fwd_val_q <= st1_fwd_val_d;
    rd_sel_q      <= rd_sel_d;
    rd_fwd_q      <= rd_fwd_d;
    rd_fwd_val_q  <= rd_fwd_val_d;
    wb_sel_q      <= wb_sel_d;
    wb_fwd_q      <= wb_fwd_d;
    wb_fwd_val_q  <= wb_fwd_val_d;
  end

  // Port B of a bank serves the direct read when it is the accumulate bank and
  // the writeback read when it is the retired bank; the roles never coincide.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic is_acc;
    logic is_wb;
    assign is_acc = (acc_ptr_q == PTR_W'(gi));
    assign is_wb  = (wb_ptr == PTR_W'(gi));

    acc_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (BANK_ADDR_WIDTH),
      .DEPTH      (BANK_DEPTH)
    ) u_bank (
      .clk       (clk),
      .we        (wr_en && (st1_bank_q == PTR_W'(gi))),
      .wadr      (st1_adr_q),
      .wdata     (wr_data),
      .rd_en_a   (acc_valid && is_acc),
      .rd_adr_a  (acc_adr),
      .rd_data_a (bank_rd_a[gi]),
      .rd_en_b   ((ren && is_acc) || (ren_wb && is_wb)),
      .rd_adr_b  (is_acc ? radr : radr_wb),
      .rd_data_b (bank_rd_b[gi])
    );
  end

  assign acc_ptr  = acc_ptr_q;
  assign acc_busy = st1_valid_q;

endmodule
